// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Generates per-stage hold/flush controls from load-use, EX-resolved
// branches, data-memory wait and fetch wait. A pending PC redirect is kept
// until fetch accepts it. Stall cycles and accepted redirects are counted.
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic              id_rs1_en,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_rs2_en,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              if_ready,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              stall_idex,
  output logic              stall_exmem,
  output logic              stall_memwb,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {
    RUN  = 1'b0,  // normal flow
    RDIR = 1'b1   // redirect issued, waiting for fetch to take it
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rdir_pc, rdir_pc_nx;
  logic              memstall;
  logic              loaduse;
  logic              accept;

  // Data memory still busy: the whole pipeline must freeze.
  assign memstall = mem_req & ~mem_ready;

  // EX load writes a register the ID instruction actually reads (x0 never hazards).
  assign loaduse = ex_is_load & (ex_rd != '0) &
                   ((id_rs1_en & (id_rs1 == ex_rd)) |
                    (id_rs2_en & (id_rs2 == ex_rd)));

  // Next-state and zero-latency control outputs from state and inputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nx       = state;
    rdir_pc_nx     = rdir_pc;
    accept         = 1'b0;
    stall_pc       = 1'b0;
    stall_ifid     = 1'b0;
    stall_idex     = 1'b0;
    stall_exmem    = 1'b0;
    stall_memwb    = 1'b0;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    if (!rst) begin
      unique case (state)
        RUN: begin
          if (memstall) begin
            // EX is frozen, so a branch there is simply re-presented later.
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            stall_memwb = 1'b1;
          end else if (ex_br_taken) begin
            // Branch beats load-use: the ID instruction is wrong-path anyway.
            redirect_valid = 1'b1;
            redirect_pc    = ex_br_target;
            flush_ifid     = 1'b1;
            flush_idex     = 1'b1;
            if (if_ready) begin
              accept = 1'b1;
            end else begin
              state_nx   = RDIR;
              rdir_pc_nx = ex_br_target;
            end
          end else if (loaduse) begin
            // One bubble; the load leaves EX next cycle and the hazard clears.
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (!if_ready) begin
            stall_pc   = 1'b1;
            flush_ifid = 1'b1;
          end
        end

        RDIR: begin
          // PC is overwritten by the redirect, so it is not held.
          redirect_valid = 1'b1;
          redirect_pc    = rdir_pc;
          flush_ifid     = 1'b1;
          flush_idex     = 1'b1;
          if (memstall) begin
            stall_exmem = 1'b1;
            stall_memwb = 1'b1;
          end else if (if_ready) begin
            accept   = 1'b1;
            state_nx = RUN;
          end
        end
      endcase
    end
  end

  // State, pending target and performance counters (counters wrap naturally).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= RUN;
      rdir_pc   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state   <= state_nx;
      rdir_pc <= rdir_pc_nx;
      if (stall_pc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (accept)   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: constant vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [4:0]  rs1;
    logic        rs1_en;
    logic [4:0]  rs2;
    logic        rs2_en;
    logic [4:0]  rd;
    logic        ld;
    logic        br;
    logic [31:0] tgt;
    logic        mreq;
    logic        mrdy;
    logic        ifr;
  } in_t;

  // stall = {pc, ifid, idex, exmem, memwb}; flush = {ifid, idex}
  typedef struct packed {
    logic [4:0]  stall;
    logic [1:0]  flush;
    logic        rv;
    logic [31:0] rpc;
  } out_t;

  typedef struct {
    in_t        in;
    logic [4:0] stall;
    logic [1:0] flush;
    logic       rv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_en, id_rs2_en, ex_is_load, ex_br_taken;
  logic [31:0] ex_br_target;
  logic        mem_req, mem_ready, if_ready;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic        flush_ifid, flush_idex, redirect_valid;
  logic [31:0] redirect_pc, stall_cnt, flush_cnt;

  logic        n_stall_pc, n_stall_ifid, n_stall_idex, n_stall_exmem, n_stall_memwb;
  logic        n_flush_ifid, n_flush_idex, n_redirect_valid;
  logic [31:0] n_redirect_pc;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int total = 0;
  int bad   = 0;

  // Model state
  logic        m_pend;
  logic [31:0] m_pc;
  longint      m_scnt, m_fcnt;
  out_t        s_o;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_ready(if_ready),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter build to exercise wrap-around.
  pipe_ctrl #(.ADDR_W(32), .REG_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_ready(if_ready),
    .stall_pc(n_stall_pc), .stall_ifid(n_stall_ifid), .stall_idex(n_stall_idex),
    .stall_exmem(n_stall_exmem), .stall_memwb(n_stall_memwb),
    .flush_ifid(n_flush_ifid), .flush_idex(n_flush_idex),
    .redirect_valid(n_redirect_valid), .redirect_pc(n_redirect_pc),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mkin(input logic ld, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic rs1_en,
                               input logic [4:0] rs2, input logic rs2_en,
                               input logic br, input logic mreq, input logic mrdy,
                               input logic ifr);
    in_t i;
    i.ld = ld; i.rd = rd; i.rs1 = rs1; i.rs1_en = rs1_en;
    i.rs2 = rs2; i.rs2_en = rs2_en; i.br = br; i.tgt = 32'h0000_0100;
    i.mreq = mreq; i.mrdy = mrdy; i.ifr = ifr;
    return i;
  endfunction

  // Expected controls: a pending redirect dominates; otherwise the
  // pipeline-wide freeze, then branch, then load-use, then fetch wait.
  function automatic out_t model_out(input in_t i, input logic r);
    out_t o;
    logic ms, lu;
    o  = '0;
    ms = i.mreq && !i.mrdy;
    lu = i.ld && (i.rd != 0) &&
         ((i.rs1_en && i.rs1 == i.rd) || (i.rs2_en && i.rs2 == i.rd));
    if (r) return o;
    if (m_pend) begin
      o.rv = 1'b1; o.rpc = m_pc; o.flush = 2'b11;
      o.stall = ms ? 5'b00011 : 5'b00000;
    end else if (ms) begin
      o.stall = 5'b11111;
    end else if (i.br) begin
      o.rv = 1'b1; o.rpc = i.tgt; o.flush = 2'b11;
    end else if (lu) begin
      o.stall = 5'b11000; o.flush = 2'b01;
    end else if (!i.ifr) begin
      o.stall = 5'b10000; o.flush = 2'b10;
    end
    return o;
  endfunction

  // A shown redirect is either taken by fetch (counted) or stays pending.
  task automatic model_update(input in_t i, input logic r, input out_t o);
    if (r) begin
      m_pend = 1'b0; m_pc = '0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (o.stall[4]) m_scnt++;
      if (o.rv) begin
        if (i.ifr && !(i.mreq && !i.mrdy)) begin
          m_fcnt++;
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
          m_pc   = o.rpc;
        end
      end
    end
  endtask

  // One clock: drive, compare at negedge, advance model on the edge.
  task automatic cycle(input in_t i, input logic r);
    out_t e;
    rst = r;
    id_rs1 = i.rs1; id_rs1_en = i.rs1_en; id_rs2 = i.rs2; id_rs2_en = i.rs2_en;
    ex_rd = i.rd; ex_is_load = i.ld; ex_br_taken = i.br; ex_br_target = i.tgt;
    mem_req = i.mreq; mem_ready = i.mrdy; if_ready = i.ifr;
    @(negedge clk);
    e = model_out(i, r);
    s_o.stall = {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb};
    s_o.flush = {flush_ifid, flush_idex};
    s_o.rv    = redirect_valid;
    s_o.rpc   = redirect_pc;
    check("cyc_stall", 64'(s_o.stall), 64'(e.stall));
    check("cyc_flush", 64'(s_o.flush), 64'(e.flush));
    check("cyc_rv",    64'(s_o.rv),    64'(e.rv));
    check("cyc_rpc",   64'(s_o.rpc),   64'(e.rpc));
    check("cyc_scnt",  64'(stall_cnt),  64'(m_scnt % 64'h1_0000_0000));
    check("cyc_fcnt",  64'(flush_cnt),  64'(m_fcnt % 64'h1_0000_0000));
    check("cyc_scnt4", 64'(stall_cnt4), 64'(m_scnt % 16));
    check("cyc_fcnt4", 64'(flush_cnt4), 64'(m_fcnt % 16));
    @(posedge clk);
    model_update(i, r, e);
    #1;
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    in_t  idle, i;

    m_pend = 1'b0; m_pc = '0; m_scnt = 0; m_fcnt = 0; s_o = '0;
    idle = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset state: outputs zero while rst, counters zero after.
    cycle(mkin(1, 5, 5, 1, 0, 0, 1, 0, 0, 0), 1'b1);
    check("rst_outputs", 64'(s_o), 64'h0);
    check("rst_scnt", 64'(stall_cnt), 64'h0);
    check("rst_fcnt", 64'(flush_cnt), 64'h0);

    // Single-cycle vectors, each applied from RUN.
    v.in = idle;                                        v.stall = 5'b00000; v.flush = 2'b00; v.rv = 0; vecs.push_back(v);
    v.in = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);          v.stall = 5'b10000; v.flush = 2'b10; v.rv = 0; vecs.push_back(v);
    v.in = mkin(1, 5, 5, 1, 1, 1, 0, 0, 0, 1);          v.stall = 5'b11000; v.flush = 2'b01; v.rv = 0; vecs.push_back(v);
    v.in = mkin(1, 5, 2, 1, 5, 1, 0, 0, 0, 1);          v.stall = 5'b11000; v.flush = 2'b01; v.rv = 0; vecs.push_back(v);
    v.in = mkin(1, 0, 0, 1, 0, 1, 0, 0, 0, 1);          v.stall = 5'b00000; v.flush = 2'b00; v.rv = 0; vecs.push_back(v);
    v.in = mkin(1, 5, 5, 0, 5, 0, 0, 0, 0, 1);          v.stall = 5'b00000; v.flush = 2'b00; v.rv = 0; vecs.push_back(v);
    v.in = mkin(0, 5, 5, 1, 5, 1, 0, 0, 0, 1);          v.stall = 5'b00000; v.flush = 2'b00; v.rv = 0; vecs.push_back(v);
    v.in = mkin(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);          v.stall = 5'b00000; v.flush = 2'b11; v.rv = 1; vecs.push_back(v);
    v.in = mkin(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);          v.stall = 5'b00000; v.flush = 2'b11; v.rv = 1; vecs.push_back(v);
    v.in = mkin(1, 5, 5, 1, 0, 0, 1, 0, 0, 1);          v.stall = 5'b00000; v.flush = 2'b11; v.rv = 1; vecs.push_back(v);
    v.in = mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);          v.stall = 5'b11111; v.flush = 2'b00; v.rv = 0; vecs.push_back(v);
    v.in = mkin(1, 5, 5, 1, 0, 0, 1, 1, 0, 0);          v.stall = 5'b11111; v.flush = 2'b00; v.rv = 0; vecs.push_back(v);
    v.in = mkin(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);          v.stall = 5'b00000; v.flush = 2'b00; v.rv = 0; vecs.push_back(v);
    v.in = mkin(1, 7, 0, 0, 7, 1, 0, 0, 0, 0);          v.stall = 5'b11000; v.flush = 2'b01; v.rv = 0; vecs.push_back(v);
    v.in = mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);          v.stall = 5'b00000; v.flush = 2'b00; v.rv = 0; vecs.push_back(v);

    foreach (vecs[k]) begin
      cycle(vecs[k].in, 1'b0);
      check($sformatf("vec%0d_stall", k), 64'(s_o.stall), 64'(vecs[k].stall));
      check($sformatf("vec%0d_flush", k), 64'(s_o.flush), 64'(vecs[k].flush));
      check($sformatf("vec%0d_rv", k),    64'(s_o.rv),    64'(vecs[k].rv));
      cycle(idle, 1'b1);
    end

    // Load-use: exactly one bubble, then clear.
    cycle(mkin(1, 5, 5, 1, 1, 1, 0, 0, 0, 1), 1'b0);
    check("lu_stall", 64'(s_o.stall), 64'(5'b11000));
    check("lu_flush", 64'(s_o.flush), 64'(2'b01));
    cycle(idle, 1'b0);
    check("lu_after", 64'({s_o.stall, s_o.flush}), 64'h0);
    check("lu_scnt", 64'(stall_cnt), 64'd1);
    cycle(mkin(1, 0, 0, 1, 0, 0, 0, 0, 0, 1), 1'b0);
    check("lu_x0_stall", 64'(s_o.stall), 64'h0);
    check("lu_x0_scnt", 64'(stall_cnt), 64'd1);

    // Taken branch accepted immediately.
    cycle(idle, 1'b1);
    cycle(mkin(0, 0, 0, 0, 0, 0, 1, 0, 0, 1), 1'b0);
    check("br_rv", 64'(s_o.rv), 64'd1);
    check("br_rpc", 64'(s_o.rpc), 64'h100);
    check("br_flush", 64'(s_o.flush), 64'(2'b11));
    cycle(idle, 1'b0);
    check("br_next_rv", 64'(s_o.rv), 64'd0);
    check("br_fcnt", 64'(flush_cnt), 64'd1);

    // Branch while fetch is busy for three cycles.
    cycle(idle, 1'b1);
    cycle(mkin(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0);
    for (int k = 0; k < 2; k++) begin
      cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      check("rdir_rv", 64'(s_o.rv), 64'd1);
      check("rdir_rpc", 64'(s_o.rpc), 64'h100);
      check("rdir_flush", 64'(s_o.flush), 64'(2'b11));
      check("rdir_stall_pc", 64'(s_o.stall[4]), 64'd0);
    end
    check("rdir_fcnt_wait", 64'(flush_cnt), 64'd0);
    cycle(idle, 1'b0);
    check("rdir_acc_rv", 64'(s_o.rv), 64'd1);
    check("rdir_acc_rpc", 64'(s_o.rpc), 64'h100);
    check("rdir_fcnt", 64'(flush_cnt), 64'd1);
    cycle(idle, 1'b0);
    check("rdir_done_rv", 64'(s_o.rv), 64'd0);

    // Memory stall masks branch and load-use, then the branch goes out.
    cycle(idle, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cycle(mkin(1, 5, 5, 1, 0, 0, 1, 1, 0, 1), 1'b0);
      check("ms_stall", 64'(s_o.stall), 64'(5'b11111));
      check("ms_rv", 64'(s_o.rv), 64'd0);
    end
    cycle(mkin(1, 5, 5, 1, 0, 0, 1, 1, 1, 1), 1'b0);
    check("ms_rel_rv", 64'(s_o.rv), 64'd1);
    check("ms_rel_rpc", 64'(s_o.rpc), 64'h100);
    check("ms_scnt", 64'(stall_cnt), 64'd4);
    check("ms_fcnt", 64'(flush_cnt), 64'd1);

    // Reset while a redirect is pending.
    cycle(idle, 1'b1);
    cycle(mkin(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0);
    cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    check("rrst_outputs", 64'(s_o), 64'h0);
    cycle(idle, 1'b0);
    check("rrst_rv", 64'(s_o.rv), 64'd0);
    check("rrst_scnt", 64'(stall_cnt), 64'd0);
    check("rrst_fcnt", 64'(flush_cnt), 64'd0);

    // Counter wrap on the 4-bit build.
    cycle(idle, 1'b1);
    for (int k = 0; k < 15; k++) cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    check("wrap_15", 64'(stall_cnt4), 64'd15);
    cycle(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    check("wrap_0", 64'(stall_cnt4), 64'd0);
    check("wrap_wide", 64'(stall_cnt), 64'd16);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      i.rs1    = 5'($urandom_range(0, 3));
      i.rs1_en = 1'($urandom);
      i.rs2    = 5'($urandom_range(0, 3));
      i.rs2_en = 1'($urandom);
      i.rd     = 5'($urandom_range(0, 3));
      i.ld     = 1'($urandom);
      i.br     = ($urandom_range(0, 3) == 0);
      i.tgt    = $urandom;
      i.mreq   = ($urandom_range(0, 2) == 0);
      i.mrdy   = 1'($urandom);
      i.ifr    = ($urandom_range(0, 2) != 0);
      cycle(i, ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB). It generates per-stage stall (hold) and flush (load NOP/ZeroPc) controls from these inputs: load-use hazards, taken branches/jumps resolved in EX, data-memory wait, and instruction-fetch wait. A small FSM holds a pending PC redirect until fetch accepts it. Stall and flush cycles are counted for performance monitoring.

Parameters:
ADDR_W, 32, PC/target width (matches AddrBus)
REG_W, 5, register index width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1  in  REG_W  source reg 1 of instruction in ID
id_rs1_en  in  1  ID reads rs1
id_rs2  in  REG_W  source reg 2 of instruction in ID
id_rs2_en  in  1  ID reads rs2
ex_rd  in  REG_W  destination reg of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_br_taken  in  1  EX resolved taken branch/jump
ex_br_target  in  ADDR_W  redirect target from EX
mem_req  in  1  MEM stage has an outstanding data access
mem_ready  in  1  data memory completes access this cycle
if_ready  in  1  fetch unit accepts PC/redirect this cycle
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID (drives the IF/ID wait input)
stall_idex  out  1  hold ID/EX
stall_exmem  out  1  hold EX/MEM
stall_memwb  out  1  hold MEM/WB
flush_ifid  out  1  load NOP into IF/ID
flush_idex  out  1  load NOP into ID/EX
redirect_valid  out  1  PC must be loaded with redirect_pc
redirect_pc  out  ADDR_W  redirect target
stall_cnt  out  CNT_W  cycles with stall_pc=1
flush_cnt  out  CNT_W  accepted redirects

Behaviour:
- Reset: rst is synchronous and active-high; the clock is clk. On reset: FSM=RUN, rdir_pc=0, stall_cnt=0, flush_cnt=0. While rst=1, all combinational outputs are 0 and redirect_pc=0. Reset during RDIR drops the pending redirect.
- memstall = mem_req & ~mem_ready. When memstall=1: all five stall_* are 1, flushes are 0, and the FSM holds state. No new redirect is taken, because EX is frozen and re-presents the branch.
- loaduse = ex_is_load & ex_rd!=0 & ((id_rs1_en & id_rs1==ex_rd) | (id_rs2_en & id_rs2==ex_rd)).
- RUN, priority highest first:
  1. memstall: as above.
  2. ex_br_taken: redirect_valid=1, redirect_pc=ex_br_target, flush_ifid=1, flush_idex=1, no stalls. If if_ready=1, flush_cnt increments and the FSM stays in RUN. Otherwise rdir_pc<=ex_br_target and the FSM goes to RDIR.
  3. loaduse: stall_pc=1, stall_ifid=1, flush_idex=1 (one bubble). The hazard clears the next cycle as the load leaves EX.
  4. ~if_ready: stall_pc=1, flush_ifid=1 (bubble into ID).
  5. else: all outputs 0.
- Branch beats load-use because the ID instruction is wrong-path.
- RDIR (redirect pending):
  - redirect_valid=1, redirect_pc=rdir_pc, flush_ifid=1, flush_idex=1.
  - stall_pc=0, because the PC is overwritten by the redirect.
  - Later stages flow unless memstall, which stalls EX/MEM and MEM/WB and holds RDIR.
  - if_ready=1 & ~memstall: flush_cnt increments, go to RUN.
  - ex_br_taken in RDIR cannot occur (EX holds a bubble) and is ignored.
- The outputs are combinational from state and inputs, with zero latency. Counters and the FSM are registered.
- stall_cnt increments on every cycle with stall_pc=1, including memstall cycles. Both counters wrap modulo 2^CNT_W.
- Same-cycle memstall & ex_br_taken: memstall wins and the redirect is issued on the first cycle memstall=0.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 (rs1_en=1) -> exactly 1 cycle of stall_pc=stall_ifid=flush_idex=1, then all 0; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Taken branch with if_ready=1, target 0x0000_0100 -> same cycle redirect_valid=1, redirect_pc=0x100, flush_ifid=flush_idex=1; next cycle redirect_valid=0; flush_cnt=1.
- Branch with if_ready=0 for 3 cycles -> redirect_valid=1 with redirect_pc=0x100 held 4 cycles (FSM in RDIR), flush_ifid=1 throughout; flush_cnt increments only on the accepting cycle.
- mem_req=1, mem_ready=0 for 4 cycles while ex_br_taken=1 and loaduse=1 -> all stalls=1, no redirect; then mem_ready=1 -> redirect issued that cycle; stall_cnt=4.
- rst asserted while in RDIR -> next cycle redirect_valid=0, counters 0, FSM=RUN.
- Counter wrap: preload stall_cnt near 2^CNT_W-1 via forced stalls (CNT_W=4 build) -> value 15 wraps to 0.
